// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle controller: opcodes, FSM state encoding,
// ALU class and writeback-source codes, and the instruction class enum.
package ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_JUMP   = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_I    = 3'd2,
        CLS_L    = 3'd3,
        CLS_S    = 3'd4,
        CLS_B    = 3'd5,
        CLS_J    = 3'd6
    } cls_e;

    // Classes that redirect the PC during EXEC.
    function automatic logic cls_redirects(input cls_e c);
        return (c == CLS_B) || (c == CLS_J);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = environment.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       instr_valid;
    logic       mem_ready;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [1:0] mem_to_reg;
    logic [2:0] state;
    logic       illegal;

    modport master (
        input  opcode, instr_valid, mem_ready,
        output imem_req, ir_write, pc_write, alu_src, branch, mem_read,
               mem_write, reg_write, alu_op, mem_to_reg, state, illegal
    );

    modport slave (
        output opcode, instr_valid, mem_ready,
        input  imem_req, ir_write, pc_write, alu_src, branch, mem_read,
               mem_write, reg_write, alu_op, mem_to_reg, state, illegal
    );
endinterface

// File: rtl/multicycle_control_decode.sv
// ctrl_decode: purely combinational opcode classifier feeding the controller FSM
// and its datapath select outputs.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_legal,
    output logic       o_alu_src,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_mem_to_reg,
    output cls_e       o_cls
);

    // Opcode to class and datapath selects; unlisted opcodes decode to all zeros.
    always_comb begin
        o_legal      = 1'b0;
        o_alu_src    = 1'b0;
        o_alu_op     = ALU_ADD;
        o_mem_to_reg = WB_ALU;
        o_cls        = CLS_NONE;
        case (i_opcode)
            OP_R: begin
                o_legal = 1'b1; o_alu_op = ALU_RTYPE; o_cls = CLS_R;
            end
            OP_I: begin
                o_legal = 1'b1; o_alu_src = 1'b1; o_cls = CLS_I;
            end
            OP_L: begin
                o_legal = 1'b1; o_alu_src = 1'b1; o_mem_to_reg = WB_MEM; o_cls = CLS_L;
            end
            OP_S: begin
                o_legal = 1'b1; o_alu_src = 1'b1; o_cls = CLS_S;
            end
            OP_B: begin
                o_legal = 1'b1; o_alu_op = ALU_BRANCH; o_cls = CLS_B;
            end
            OP_JAL: begin
                o_legal = 1'b1; o_alu_op = ALU_JUMP; o_mem_to_reg = WB_PC4; o_cls = CLS_J;
            end
            OP_JALR: begin
                o_legal = 1'b1; o_alu_src = 1'b1; o_alu_op = ALU_JUMP;
                o_mem_to_reg = WB_PC4; o_cls = CLS_J;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction controller: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Define CTRL_ILLEGAL_TRAP_EN to trap unlisted opcodes into a sticky HALT state.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    state_e     r_state;
    logic [6:0] r_opcode_q;
    logic       w_legal;
    logic       w_alu_src;
    logic [1:0] w_alu_op;
    logic [1:0] w_mem_to_reg;
    cls_e       w_cls;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       r_illegal;
`endif

    ctrl_decode u_decode (
        .i_opcode     (r_opcode_q),
        .o_legal      (w_legal),
        .o_alu_src    (w_alu_src),
        .o_alu_op     (w_alu_op),
        .o_mem_to_reg (w_mem_to_reg),
        .o_cls        (w_cls)
    );

    // State sequencing, opcode capture and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_opcode_q <= 7'd0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (bus.instr_valid) begin
                        r_opcode_q <= bus.opcode;
                        r_state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_legal) begin
                        r_state <= ST_EXEC;
                    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        r_state   <= ST_HALT;
                        r_illegal <= 1'b1;
`else
                        r_state <= ST_FETCH;
`endif
                    end
                end
                ST_EXEC: begin
                    case (w_cls)
                        CLS_R, CLS_I, CLS_J: r_state <= ST_WB;
                        CLS_L, CLS_S:        r_state <= ST_MEM;
                        default:             r_state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        r_state <= (w_cls == CLS_L) ? ST_WB : ST_FETCH;
                    end
                end
                ST_WB: begin
                    r_state <= ST_FETCH;
                end
                ST_HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    r_state <= ST_HALT;
`else
                    r_state <= ST_FETCH;
`endif
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // Output decode; rst forces everything low in the same cycle so an
    // in-flight memory access is dropped immediately.
    always_comb begin
        bus.imem_req   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.alu_src    = 1'b0;
        bus.branch     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_op     = ALU_ADD;
        bus.mem_to_reg = WB_ALU;
        bus.state      = 3'd0;
        bus.illegal    = 1'b0;
        if (rst) begin
            bus.state = 3'd0;
        end else begin
            bus.state = r_state;
`ifdef CTRL_ILLEGAL_TRAP_EN
            bus.illegal = r_illegal;
`endif
            case (r_state)
                ST_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_write = bus.instr_valid;
                    bus.pc_write = bus.instr_valid;
                end
                ST_DECODE, ST_EXEC, ST_MEM, ST_WB: begin
                    bus.alu_src    = w_alu_src;
                    bus.alu_op     = w_alu_op;
                    bus.mem_to_reg = w_mem_to_reg;
                    bus.branch     = (r_state == ST_EXEC) && cls_redirects(w_cls);
                    bus.mem_read   = (r_state == ST_MEM) && (w_cls == CLS_L);
                    bus.mem_write  = (r_state == ST_MEM) && (w_cls == CLS_S);
                    bus.reg_write  = (r_state == ST_WB);
                end
                default: begin
                    bus.imem_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port: rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port: opcode  input  7  instruction[6:0]; valid only while instr_valid=1.
REQ-004 SHALL have port: instr_valid  input  1  instruction memory has returned the fetched word.
REQ-005 SHALL have port: mem_ready  input  1  data memory has completed the current read/write.
REQ-006 SHALL have port: imem_req  output  1  instruction fetch request.
REQ-007 SHALL have ports: ir_write, pc_write  output  1 each  latch instruction register / PC+4.
REQ-008 SHALL have ports: alu_src, branch, mem_read, mem_write, reg_write  output  1 each  datapath controls.
REQ-009 SHALL have ports: alu_op, mem_to_reg  output  2 each  ALU class / writeback source select.
REQ-010 SHALL have ports: state  output  3  current FSM state; illegal  output  1  sticky illegal-opcode flag.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-012 SHALL, in FETCH, drive imem_req=1, hold until instr_valid=1, then assert ir_write=pc_write=1 that cycle, capture opcode into opcode_q, go to DECODE.
REQ-013 SHALL make ir_write/pc_write combinational on (state==FETCH && instr_valid); every other output is a function of state and opcode_q only.
REQ-014 SHALL go DECODE->EXEC unconditionally for legal opcodes 0110011 R, 0010011 I, 0000011 L, 0100011 S, 1100011 B, 1101111 JAL, 1100111 JALR.
REQ-015 SHALL go EXEC->WB for R/I/JAL/JALR, EXEC->MEM for L/S, EXEC->FETCH for B.
REQ-016 SHALL hold MEM with mem_read=1 (L) or mem_write=1 (S) until mem_ready=1; then L->WB, S->FETCH.
REQ-017 SHALL assert reg_write=1 only in WB, for exactly one cycle, then go to FETCH.
REQ-018 SHALL assert branch=1 only in EXEC for B/JAL/JALR.
REQ-019 SHALL drive alu_src (1 for I/L/S/JALR, else 0) and alu_op (10 R; 00 I/L/S; 01 B; 11 JAL/JALR) in DECODE through WB; both 0 in FETCH.
REQ-020 SHALL drive mem_to_reg 00 R/I, 01 L, 10 JAL/JALR in DECODE through WB; 00 elsewhere.
REQ-021 SHALL give latencies (instr_valid, mem_ready tied 1): B 3 cycles; R/I/JAL/JALR/S 4; L 5.
REQ-022 SHALL ignore mem_ready outside MEM and instr_valid outside FETCH.

Reset
REQ-023 SHALL on rst=1 set state=FETCH, opcode_q=0, illegal=0; rst dominates all other inputs.
REQ-024 SHALL force every output to 0 in any cycle where rst=1, including mid-MEM wait (pending access abandoned).

Configuration
REQ-025 SHALL, with CTRL_ILLEGAL_TRAP_EN defined, go DECODE->HALT on a non-listed opcode, set illegal=1, and stay in HALT with all strobes 0 until rst.
REQ-026 SHALL, without CTRL_ILLEGAL_TRAP_EN, go DECODE->FETCH on a non-listed opcode (NOP), tie illegal=0, and never enter HALT.

Structure
REQ-027 SHALL place opcode constants, state encoding and alu_op/mem_to_reg codes in package ctrl_pkg.
REQ-028 SHALL use one sub-module ctrl_decode: combinational opcode_q -> {legal, alu_src, alu_op, mem_to_reg, class}.

Verification
REQ-029 SHALL cover: R add 0110011, instr_valid=1, mem_ready=1 -> states 0,1,2,4,0; reg_write=1 only in WB; alu_op=10.
REQ-030 SHALL cover: load 0000011, mem_ready low 3 cycles in MEM -> mem_read=1 for 4 cycles, then WB with mem_to_reg=01, 8 cycles total.
REQ-031 SHALL cover: beq 1100011 -> 3-cycle sequence, branch=1 only in EXEC, reg_write never 1.
REQ-032 SHALL cover: instr_valid low 2 cycles in FETCH -> imem_req held 3 cycles, single ir_write pulse on third.
REQ-033 SHALL cover: opcode 1111111 -> with CTRL_ILLEGAL_TRAP_EN state=5 and illegal=1 until rst; without, back to FETCH.
REQ-034 SHALL cover: rst asserted during MEM wait of store -> next cycle state=0, mem_write=0.
